uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Frame sequencer for the UART transmit path. Accepts one parallel word per
//  Data_Valid pulse and steps the TX datapath through the frame:
//  start bit, WIDTH data bits LSB first, optional parity bit, stop bit.
//  Drives the serializer shift enable, the load strobe shared by the
//  serializer and parity calculator, and the 4:1 TX output mux select.
//  Sits between the system controller (word source) and the TX datapath.
// PARAMETERS
//  WIDTH    8   data bits per frame; also the serializer/parity width (>=2)
//  CNT_W    $clog2(WIDTH)   bit-counter width
// PORTS
//  CLK         in   1      single clock; every flop is rising-edge
//  RST         in   1      asynchronous, active-low reset
//  Data_Valid  in   1      new word present; sampled only when accepted
//  PAR_EN      in   1      parity enable; captured at accept
//  PAR_TYP     in   1      0=even, 1=odd; captured at accept
//  data_load   out  1      1-cycle strobe: serializer and parity calc latch word
//  ser_en      out  1      serializer shift enable (one data bit per cycle)
//  mux_sel     out  2      00 start(0), 01 serial data, 10 parity, 11 idle/stop(1)
//  par_en_q    out  1      PAR_EN as captured for current frame
//  par_typ_q   out  1      PAR_TYP as captured for current frame
//  busy        out  1      frame in progress
// BEHAVIOUR
//  - Reset (RST=0, any time, incl. mid-frame): state=IDLE, bit counter=0,
//    data_load=0, ser_en=0, mux_sel=11, par_en_q=0, par_typ_q=0, busy=0.
//    The line returns to idle-high at once; the partial frame is discarded.
//  - All outputs are registered or decoded from registered state only.
//    There is no combinational path from inputs to outputs.
//  - States: IDLE, START, DATA, PARITY, STOP.
//  - Accept: Data_Valid=1 in IDLE, or in STOP (back-to-back frames).
//    On accept, capture PAR_EN and PAR_TYP. Next state is START.
//    When Data_Valid=1 in START, DATA or PARITY, the word is ignored and
//    not queued.
//  - START (1 cycle): mux_sel=00, busy=1, data_load=1. Next state is DATA.
//  - DATA (WIDTH cycles): mux_sel=01, ser_en=1, busy=1.
//    The counter runs 0..WIDTH-1.
//    At WIDTH-1 the counter clears. Next state is PARITY if par_en_q=1,
//    otherwise STOP.
//  - PARITY (1 cycle): mux_sel=10, busy=1.
//  - STOP (1 cycle): mux_sel=11, busy=1.
//    Next state is START if Data_Valid=1, otherwise IDLE.
//  - IDLE: mux_sel=11, busy=0, ser_en=0, data_load=0.
//  - Latency: accept at edge N puts START on cycles N+1. The frame lasts
//    WIDTH+2 cycles, or WIDTH+3 with parity.
//    busy covers exactly the START..STOP span.
//  - par_en_q and par_typ_q hold stable for the whole frame. Changes on the
//    PAR_EN/PAR_TYP inputs mid-frame do not affect the frame in progress.
//  - Undefined state encodings recover to IDLE on the next edge.
// STRUCTURE
//  - Shared package uart_tx_pkg holds the state encoding and the mux_sel
//    constants (MUX_START, MUX_DATA, MUX_PAR, MUX_IDLE).
//    The TX top-level mux uses the same package.
//  - One sub-module, uart_tx_bit_cnt: CNT_W-bit counter with inputs
//    en and clr, and output last (= count==WIDTH-1).
//  - Everything else is the next-state logic and the output decode.
// TESTING
//  1. Reset mid-DATA (cycle 4 of frame): RST low -> busy=0, mux_sel=11,
//     ser_en=0 asynchronously, before the next edge. After release the
//     block stays IDLE until Data_Valid.
//  2. WIDTH=8, PAR_EN=0, one Data_Valid pulse -> mux_sel 00,01x8,11 over
//     10 cycles. Also check: data_load high only in the START cycle,
//     ser_en high exactly 8 cycles, then IDLE.
//  3. PAR_EN=1, PAR_TYP=1 -> 11-cycle frame with mux_sel=10 in cycle 10.
//     par_typ_q=1 throughout. Toggling PAR_EN/PAR_TYP mid-frame leaves
//     the sequence unchanged.
//  4. Data_Valid asserted in the STOP cycle -> START on the very next cycle.
//     busy stays 1 with no idle gap between the two frames.
//  5. Data_Valid pulses during START, DATA and PARITY -> ignored. No extra
//     frame follows, and data_load is never re-asserted.
//  6. Data_Valid held high for 3 frames -> three back-to-back frames of
//     WIDTH+2/+3 cycles each. The bit counter never exceeds WIDTH-1.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: frame sequencer state encoding
// and the TX output mux select codes.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } tx_state_e;

  localparam logic [1:0] MUX_START = 2'b00;
  localparam logic [1:0] MUX_DATA  = 2'b01;
  localparam logic [1:0] MUX_PAR   = 2'b10;
  localparam logic [1:0] MUX_IDLE  = 2'b11;

  function automatic logic [1:0] state_mux_sel(input tx_state_e st);
    logic [1:0] sel;
    sel = MUX_IDLE;
    case (st)
      StStart:  sel = MUX_START;
      StData:   sel = MUX_DATA;
      StParity: sel = MUX_PAR;
      default:  sel = MUX_IDLE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/uart_tx_bit_cnt.sv
// Data-bit counter for the frame sequencer: counts 0..WIDTH-1 while enabled and
// wraps to zero after the last bit.
module uart_tx_bit_cnt #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic last
);

  logic [CNT_W-1:0] cnt_q;

  assign last = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: steps the TX datapath through start, data,
// optional parity and stop, with all outputs registered.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Data_Valid,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       data_load,
  output logic       ser_en,
  output logic [1:0] mux_sel,
  output logic       par_en_q,
  output logic       par_typ_q,
  output logic       busy
);

  tx_state_e state_q, state_d;
  logic      accept;
  logic      cnt_last;

  // A new word is taken only when the line is free or finishing its stop bit.
  assign accept = Data_Valid && ((state_q == StIdle) || (state_q == StStop));

  uart_tx_bit_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .en    (state_q == StData),
    .clr   (state_q != StData),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = StIdle;
    case (state_q)
      StIdle:   state_d = accept ? StStart : StIdle;
      StStart:  state_d = StData;
      StData:   state_d = cnt_last ? (par_en_q ? StParity : StStop) : StData;
      StParity: state_d = StStop;
      StStop:   state_d = accept ? StStart : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      data_load <= 1'b0;
      ser_en    <= 1'b0;
      mux_sel   <= MUX_IDLE;
      busy      <= 1'b0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_load <= (state_d == StStart);
      ser_en    <= (state_d == StData);
      mux_sel   <= state_mux_sel(state_d);
      busy      <= (state_d != StIdle);
      if (accept) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: frame-level queue model checked every cycle, plus
// directed frames with hand-computed expectations and randomized traffic.
module tb_uart_tx_ctrl;

  localparam int unsigned W = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       data_load, ser_en, par_en_q, par_typ_q, busy;
  logic [1:0] mux_sel;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  uart_tx_ctrl #(
    .WIDTH (W)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .data_load  (data_load),
    .ser_en     (ser_en),
    .mux_sel    (mux_sel),
    .par_en_q   (par_en_q),
    .par_typ_q  (par_typ_q),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Model: a frame is a list of line symbols (0 start, 1 data, 2 parity, 3 stop).
  int         sched[$];
  logic       m_busy = 1'b0;
  logic [1:0] m_mux = 2'b11;
  logic       m_pe = 1'b0;
  logic       m_pt = 1'b0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sched.delete();
      m_busy = 1'b0;
      m_mux  = 2'b11;
      m_pe   = 1'b0;
      m_pt   = 1'b0;
    end else begin
      if ((!m_busy || sched.size() == 0) && Data_Valid) begin
        m_pe = PAR_EN;
        m_pt = PAR_TYP;
        sched.delete();
        sched.push_back(0);
        repeat (W) sched.push_back(1);
        if (m_pe) sched.push_back(2);
        sched.push_back(3);
      end
      if (sched.size() > 0) begin
        m_mux  = 2'(sched.pop_front());
        m_busy = 1'b1;
      end else begin
        m_mux  = 2'b11;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      logic [6:0] act, exp;
      act = {data_load, ser_en, mux_sel, par_en_q, par_typ_q, busy};
      exp = {m_busy && m_mux == 2'b00, m_busy && m_mux == 2'b01, m_mux, m_pe, m_pt, m_busy};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model t=%0t {load,ser,mux,pe,pt,busy} got %b expected %b", $time, act, exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input logic dv, input logic pe, input logic pt);
    @(posedge CLK);
    #3;
    Data_Valid = dv;
    PAR_EN     = pe;
    PAR_TYP    = pt;
  endtask

  logic [1:0] r_mux[$];
  logic       r_load[$], r_ser[$], r_busy[$], r_pt[$];

  task automatic rec_clear();
    r_mux.delete(); r_load.delete(); r_ser.delete(); r_busy.delete(); r_pt.delete();
  endtask

  task automatic tick_rec(input logic dv, input logic pe, input logic pt);
    tick(dv, pe, pt);
    @(negedge CLK);
    r_mux.push_back(mux_sel);
    r_load.push_back(data_load);
    r_ser.push_back(ser_en);
    r_busy.push_back(busy);
    r_pt.push_back(par_typ_q);
  endtask

  logic [1:0] exp2 [12] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
                            2'd3, 2'd3, 2'd3};

  initial begin
    int nl, ns, nb, npt, max_cnt, dens;
    #1 RST = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_mux", mux_sel, 3);
    chk("rst_load", data_load, 0);
    chk("rst_ser", ser_en, 0);
    chk("rst_pe", par_en_q, 0);
    chk("rst_pt", par_typ_q, 0);
    @(posedge CLK);
    #3 RST = 1'b1;
    repeat (2) tick(0, 0, 0);

    // 1: asynchronous reset in the middle of the data bits
    tick(1, 0, 0);
    repeat (4) tick(0, 0, 0);
    chk("t1_pre_ser", ser_en, 1);
    RST = 1'b0;
    #1;
    chk("t1_async_busy", busy, 0);
    chk("t1_async_mux", mux_sel, 3);
    chk("t1_async_ser", ser_en, 0);
    tick(0, 0, 0);
    RST = 1'b1;
    rec_clear();
    for (int k = 0; k < 5; k++) tick_rec(0, 0, 0);
    nb = 0;
    for (int k = 0; k < 5; k++) nb += int'(r_busy[k]);
    chk("t1_stays_idle", nb, 0);

    // 2: plain frame, no parity
    rec_clear();
    tick(1, 0, 0);
    for (int k = 0; k < 12; k++) tick_rec(0, 0, 0);
    nl = 0; ns = 0; nb = 0;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("t2_mux%0d", k), r_mux[k], exp2[k]);
      nl += int'(r_load[k]);
      ns += int'(r_ser[k]);
      nb += int'(r_busy[k]);
    end
    chk("t2_load_first", r_load[0], 1);
    chk("t2_loads", nl, 1);
    chk("t2_ser_cycles", ns, 8);
    chk("t2_busy_cycles", nb, 10);

    // 3: odd parity frame with parity inputs toggling mid-frame
    rec_clear();
    tick(1, 1, 1);
    for (int k = 0; k < 13; k++) tick_rec(0, (k % 2) == 1, (k % 2) == 0);
    nb = 0; npt = 0;
    for (int k = 0; k < 13; k++) begin
      nb  += int'(r_busy[k]);
      npt += int'(r_busy[k] && r_pt[k]);
    end
    chk("t3_busy_cycles", nb, 11);
    chk("t3_last_data", r_mux[8], 1);
    chk("t3_parity_slot", r_mux[9], 2);
    chk("t3_stop_slot", r_mux[10], 3);
    chk("t3_idle_after", r_busy[11], 0);
    chk("t3_pt_held", npt, 11);

    // 4: Data_Valid in the stop cycle chains the next frame
    rec_clear();
    tick(1, 0, 0);
    for (int k = 0; k < 22; k++) tick_rec(k == 9, 0, 0);
    nb = 0;
    for (int k = 0; k < 20; k++) nb += int'(r_busy[k]);
    chk("t4_no_gap", nb, 20);
    chk("t4_stop1", r_mux[9], 3);
    chk("t4_start2", r_mux[10], 0);
    chk("t4_load2", r_load[10], 1);
    chk("t4_idle_after", r_busy[20], 0);

    // 5: Data_Valid during start, data and parity is dropped
    rec_clear();
    tick(1, 1, 0);
    for (int k = 0; k < 16; k++) tick_rec(k == 0 || k == 4 || k == 9, 1, 0);
    nl = 0; nb = 0;
    for (int k = 0; k < 16; k++) begin
      nl += int'(r_load[k]);
      nb += int'(r_busy[k]);
    end
    chk("t5_loads", nl, 1);
    chk("t5_busy_cycles", nb, 11);
    chk("t5_parity_slot", r_mux[9], 2);

    // 6: Data_Valid held for three frames
    rec_clear();
    max_cnt = 0;
    tick(1, 0, 0);
    for (int k = 0; k < 32; k++) begin
      tick_rec(k < 29, 0, 0);
      if (int'(dut.u_bit_cnt.cnt_q) > max_cnt) max_cnt = int'(dut.u_bit_cnt.cnt_q);
    end
    nl = 0; nb = 0;
    for (int k = 0; k < 32; k++) begin
      nl += int'(r_load[k]);
      nb += int'(r_busy[k]);
    end
    chk("t6_loads", nl, 3);
    chk("t6_busy_cycles", nb, 30);
    chk("t6_start3", r_load[20], 1);
    chk("t6_idle_after", r_busy[30], 0);
    chk("t6_cnt_max", max_cnt, W - 1);

    // Randomized traffic with occasional asynchronous resets
    for (int blk = 0; blk < 15; blk++) begin
      dens = int'($urandom_range(0, 3));
      for (int k = 0; k < 200; k++) begin
        tick($urandom_range(0, 3) < dens, 1'($urandom), 1'($urandom));
        RST = ($urandom_range(0, 249) != 0);
      end
    end
    tick(0, 0, 0);
    RST = 1'b1;
    repeat (20) tick(0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
